// File: rtl/spi_controller_if.sv
// System-side register interface of the SPI controller: transfer request,
// transmit word, received word and status flags.
interface spi_controller_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] txData;
  logic [WIDTH-1:0] rxData;
  logic             busy;
  logic             done;

  // Host side: issues requests and reads back status/results.
  modport master (
    output start, txData,
    input  rxData, busy, done
  );

  // Controller side: accepts requests and reports results.
  modport slave (
    input  start, txData,
    output rxData, busy, done
  );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 master: shifts one WIDTH-bit word out on mosi (MSB first) while
// capturing the peripheral's word on miso. sclk idles low; mosi changes only
// at frame start or on falling sclk, so it is stable on every rising edge.
module spi_controller #(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_controller_if.slave   bus,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  // CLKDIV=1 still needs a one-bit counter so the compare below stays legal.
  localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] rx_data;
  logic             busy;
  logic             done;
  logic             tick;

  // A tick marks the end of one sclk half-period; every state change but
  // the initial acceptance happens on a tick.
  assign tick = (state != IDLE) && (div_cnt == DIV_W'(CLKDIV - 1));

  assign bus.rxData = rx_data;
  assign bus.busy   = busy;
  assign bus.done   = done;

  // Half-period divider: held at zero while idle, wraps on every tick.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its inputs regardless of statement order.
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (state == IDLE || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Frame sequencer: owns the pins, the shift registers and the status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= SETUP;
            tx_shift <= bus.txData;
            mosi     <= bus.txData[WIDTH-1];
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            rx_shift <= '0;
          end
        end
        SETUP: begin
          // End of the setup half-period is the first rising sclk edge.
          if (tick) begin
            sclk     <= 1'b1;
            rx_shift <= {rx_shift[WIDTH-2:0], miso};
            state    <= XFER;
          end
        end
        XFER: begin
          if (tick) begin
            if (!sclk) begin
              sclk     <= 1'b1;
              rx_shift <= {rx_shift[WIDTH-2:0], miso};
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == BIT_W'(WIDTH - 1)) begin
                // Last bit already sampled; mosi keeps its value into HOLD.
                state <= HOLD;
              end else begin
                tx_shift <= tx_shift << 1;
                mosi     <= tx_shift[WIDTH-2];
                bit_cnt  <= bit_cnt + 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state   <= IDLE;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_shift;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a CLKDIV=2 instance driven by directed and random
// frames (loopback or a shift-out peripheral model) with a scoreboard, plus a
// CLKDIV=1 loopback instance exercising back-to-back frames.
module tb_spi_controller;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  spi_controller_if #(.WIDTH(W)) if0 ();
  spi_controller_if #(.WIDTH(W)) if1 ();

  logic sclk0, cs_n0, mosi0, miso0;
  logic sclk1, cs_n1, mosi1, miso1;

  logic         loop_mode   = 1'b1;
  logic [W-1:0] periph_word = '0;
  logic         periph_bit  = 1'b0;
  int           p_idx       = 0;

  assign miso0 = loop_mode ? mosi0 : periph_bit;
  assign miso1 = mosi1;

  spi_controller #(.WIDTH(W), .CLKDIV(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0),
    .sclk(sclk0), .cs_n(cs_n0), .mosi(mosi0), .miso(miso0)
  );

  spi_controller #(.WIDTH(W), .CLKDIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1),
    .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso1)
  );

  // Peripheral model: MSB presented when cs_n falls, next bit on each falling sclk.
  always @(negedge cs_n0) begin
    p_idx      = W - 1;
    periph_bit = periph_word[W-1];
  end
  always @(negedge sclk0) begin
    if (!cs_n0 && p_idx > 0) begin
      p_idx      = p_idx - 1;
      periph_bit = periph_word[p_idx];
    end
  end

  typedef struct {
    logic [W-1:0] rx;
    logic [W-1:0] tx;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  exp_t e_drop;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the CLKDIV=2 instance: collects edge counts and mosi bits,
  // and compares against the scoreboard on every done pulse.
  int           rise0 = 0;
  int           busy0 = 0;
  logic [W-1:0] bits0 = '0;
  logic         sclk_p0 = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rise0   = 0;
      busy0   = 0;
      bits0   = '0;
      sclk_p0 = 1'b0;
    end else begin
      if (sclk0 && !sclk_p0 && !cs_n0) begin
        rise0++;
        bits0 = {bits0[W-2:0], mosi0};
      end
      sclk_p0 = sclk0;
      if (if0.busy) busy0++;
      if (if0.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rx_data", 32'(if0.rxData), 32'(e.rx));
          check("mosi_bits", 32'(bits0), 32'(e.tx));
          check("rise_edges", 32'(rise0), 32'(W));
          check("latency", 32'(cyc - e.acc), 32'((2 * W + 1) * 2));
          check("busy_cycles", 32'(busy0), 32'((2 * W + 1) * 2));
          check("cs_n_done", 32'(cs_n0), 32'd1);
        end
        rise0 = 0;
        busy0 = 0;
        bits0 = '0;
      end
    end
  end

  // Monitor for the CLKDIV=1 instance: frame period, cs_n gap and data.
  int done1_cnt  = 0;
  int last_done1 = 0;
  int hi_run1    = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cs_n1) begin
        hi_run1++;
      end else begin
        if (hi_run1 > 0 && done1_cnt > 0) check("cs_gap_div1", 32'(hi_run1), 32'd1);
        hi_run1 = 0;
      end
      if (if1.done) begin
        check("rx_div1", 32'(if1.rxData), 32'h81);
        if (done1_cnt > 0) check("period_div1", 32'(cyc - last_done1), 32'd18);
        last_done1 = cyc;
        done1_cnt++;
      end
    end
  end

  task automatic do_xfer(input logic [W-1:0] tx, input logic lp, input logic [W-1:0] pw);
    @(negedge clk);
    loop_mode   = lp;
    periph_word = pw;
    if0.txData  = tx;
    if0.start   = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{rx: (lp ? tx : pw), tx: tx, acc: cyc});
    @(negedge clk);
    if0.start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!if0.busy) break;
    end
    check("idle_timeout", 32'(if0.busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, 32'(cs_n0), 32'd1);
    check({tag, "_sclk"}, 32'(sclk0), 32'd0);
    check({tag, "_mosi"}, 32'(mosi0), 32'd0);
    check({tag, "_busy"}, 32'(if0.busy), 32'd0);
    check({tag, "_done"}, 32'(if0.done), 32'd0);
    check({tag, "_rx"}, 32'(if0.rxData), 32'd0);
  endtask

  initial begin
    logic [W-1:0] tx;
    logic [W-1:0] pw;
    logic         lp;

    if0.start  = 1'b0;
    if0.txData = '0;
    if1.start  = 1'b0;
    if1.txData = '0;

    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    check("reset_cs_n_div1", 32'(cs_n1), 32'd1);
    check("reset_rx_div1", 32'(if1.rxData), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Loopback A5.
    do_xfer(8'hA5, 1'b1, 8'h00);
    wait_idle();

    // Peripheral returns 3C while mosi is all ones.
    do_xfer(8'hFF, 1'b0, 8'h3C);
    wait_idle();

    // A second start and a txData change mid-frame must be ignored.
    do_xfer(8'h0F, 1'b1, 8'h00);
    repeat (9) @(negedge clk);
    if0.start  = 1'b1;
    if0.txData = 8'hF0;
    @(negedge clk);
    if0.start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-frame: frame abandoned, no done pulse.
    do_xfer(8'h5A, 1'b1, 8'h00);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    e_drop = sb.pop_front();
    @(negedge clk);
    rst_n = 1'b1;
    do_xfer(8'hC3, 1'b1, 8'h00);
    wait_idle();

    // Random frames in either mode.
    repeat (20) begin
      tx = W'($urandom);
      pw = W'($urandom);
      lp = 1'($urandom_range(0, 1));
      do_xfer(tx, lp, pw);
      wait_idle();
    end

    // CLKDIV=1 instance with start held high: back-to-back frames.
    @(negedge clk);
    if1.txData = 8'h81;
    if1.start  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done1_cnt >= 4) break;
    end
    check("div1_frames", 32'(done1_cnt >= 4), 32'd1);
    if1.start = 1'b0;
    repeat (30) @(negedge clk);

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI mode-0 controller (master) for the lab SPI link; it is the initiating end that drives the peripheral-side shift register.
- Generates sclk, cs_n and mosi from the system clock, transmits one WIDTH-bit word MSB-first and captures the word returned on miso.
- Sits between the system-side register interface (start/txData/rxData) and the off-chip SPI pins.

Parameters:
- WIDTH, 8, bits per transfer.
- CLKDIV, 2, clk cycles per sclk half-period; legal values ≥1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a transfer; sampled only while idle.
- txData  input  WIDTH  word to send; latched on the edge that accepts start.
- rxData  output  WIDTH  last received word; updates only on the done cycle.
- busy  output  1  high from acceptance until the done cycle (exclusive).
- done  output  1  one-cycle pulse when a transfer completes.
- sclk  output  1  SPI clock; idle low (CPOL=0).
- cs_n  output  1  chip select, active low.
- mosi  output  1  serial data out, MSB first.
- miso  input  1  serial data in from the peripheral.

Behaviour:
- Reset (asynchronous, any state) forces IDLE with sclk=0, cs_n=1, mosi=0, busy=0, done=0 and rxData=0. All counters and shift registers clear.
- States:
  - IDLE: waits for start.
  - SETUP: cs_n low, sclk low, one half-period.
  - XFER: sclk toggling.
  - HOLD: sclk low, cs_n still low, one half-period.
- Tick: divCnt counts 0..CLKDIV-1 while not IDLE. A tick occurs on the edge where divCnt=CLKDIV-1, after which divCnt wraps to 0.
- IDLE to SETUP, on an edge with start=1:
  - txShift←txData; mosi←txData[WIDTH-1]; cs_n←0; busy←1.
  - divCnt←0; bitCnt←0; rxShift←0.
- SETUP, on tick: sclk←1 (first rising edge), then go to XFER.
- Rising tick (sclk goes 0 to 1): rxShift←{rxShift[WIDTH-2:0], miso}, using the miso value present at that clk edge.
- Falling tick (sclk goes 1 to 0):
  - If bitCnt=WIDTH-1: go to HOLD; mosi holds its value.
  - Else: shift txShift left, mosi←next bit, bitCnt++.
- HOLD, on tick:
  - Go to IDLE: cs_n←1, mosi←0, busy←0, done←1 for exactly one cycle, rxData←rxShift.
- Timing and edge counts:
  - Exactly WIDTH rising and WIDTH falling sclk edges per transfer.
  - sclk has a 50% duty cycle with a half-period of CLKDIV clk cycles.
  - mosi changes only on falling ticks or at SETUP entry, so it is stable across every rising sclk edge.
- Latency: done goes high (2·WIDTH+1)·CLKDIV cycles after the accepting edge; this is 34 cycles at the defaults.
- cs_n low duration is (2·WIDTH+1)·CLKDIV cycles.
- start while busy: ignored. txData changes while busy have no effect.
- Back-to-back: start=1 during the done cycle is accepted, since the state is already IDLE. cs_n then goes high for one cycle only.
- Reset mid-transfer: cs_n rises immediately (asynchronously), no done pulse is produced, and rxData is cleared.
- CLKDIV=1: a tick occurs every cycle and sclk runs at clk/2.

Test Plan:
- Loopback (mosi wired to miso), defaults, txData=8'hA5, one start pulse → done after exactly 34 cycles, rxData=8'hA5, 8 rising sclk edges counted while cs_n=0, busy high for 34 cycles.
- Peripheral model shifts 8'h3C out on falling sclk (MSB preloaded when cs_n falls), txData=8'hFF → rxData=8'h3C. The bench also checks mosi=1 at every rising edge.
- Pulse start=1 again at cycle 10 of a transfer carrying txData=8'h0F → ignored: a single done pulse, exactly 8 rising edges, mosi pattern 00001111.
- Drive rst_n=0 at cycle 15 of a transfer → cs_n=1, sclk=0, busy=0, rxData=8'h00 immediately. No done pulse; the next transfer then completes normally.
- CLKDIV=1: start held high continuously with txData=8'h81 → successive done pulses every 18 cycles, cs_n high for 1 cycle between frames, rxData=8'h81 in loopback.
